// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline-stage register: control-bit
// indices, per-stage default widths and the ID/EX payload layout.
package pipe_pkg;

    // Control-bit positions within the CTRL_W control field
    localparam int unsigned CTRL_REGDST    = 0;
    localparam int unsigned CTRL_ALUSRC    = 1;
    localparam int unsigned CTRL_MEMTOREG  = 2;
    localparam int unsigned CTRL_REGWRITE  = 3;
    localparam int unsigned CTRL_MEMREAD   = 4;
    localparam int unsigned CTRL_MEMWRITE  = 5;
    localparam int unsigned CTRL_BRANCH    = 6;
    localparam int unsigned CTRL_JUMP      = 7;
    localparam int unsigned CTRL_ALUOP_LSB = 8;
    localparam int unsigned CTRL_ALUOP_W   = 2;
    localparam int unsigned CTRL_SPARE     = 10;

    // Default widths for each inter-stage instance
    localparam int unsigned IFID_CTRL_W  = 11;
    localparam int unsigned IFID_DATA_W  = 64;
    localparam int unsigned IDEX_CTRL_W  = 11;
    localparam int unsigned IDEX_DATA_W  = 147;
    localparam int unsigned EXMEM_CTRL_W = 11;
    localparam int unsigned EXMEM_DATA_W = 107;
    localparam int unsigned MEMWB_CTRL_W = 11;
    localparam int unsigned MEMWB_DATA_W = 71;

    // ID/EX payload field widths
    localparam int unsigned IDEX_PC_W        = 32;
    localparam int unsigned IDEX_RD1_W       = 32;
    localparam int unsigned IDEX_RD2_W       = 32;
    localparam int unsigned IDEX_IMM_W       = 16;
    localparam int unsigned IDEX_RT_W        = 5;
    localparam int unsigned IDEX_RD_W        = 5;
    localparam int unsigned IDEX_OPCODE_W    = 6;
    localparam int unsigned IDEX_OPERATION_W = 3;
    localparam int unsigned IDEX_JADDR_W     = 16;

    // ID/EX payload field LSB offsets (jump_addr occupies the low bits)
    localparam int unsigned IDEX_JADDR_LSB     = 0;
    localparam int unsigned IDEX_OPERATION_LSB = IDEX_JADDR_LSB + IDEX_JADDR_W;
    localparam int unsigned IDEX_OPCODE_LSB    = IDEX_OPERATION_LSB + IDEX_OPERATION_W;
    localparam int unsigned IDEX_RD_LSB        = IDEX_OPCODE_LSB + IDEX_OPCODE_W;
    localparam int unsigned IDEX_RT_LSB        = IDEX_RD_LSB + IDEX_RD_W;
    localparam int unsigned IDEX_IMM_LSB       = IDEX_RT_LSB + IDEX_RT_W;
    localparam int unsigned IDEX_RD2_LSB       = IDEX_IMM_LSB + IDEX_IMM_W;
    localparam int unsigned IDEX_RD1_LSB       = IDEX_RD2_LSB + IDEX_RD2_W;
    localparam int unsigned IDEX_PC_LSB        = IDEX_RD1_LSB + IDEX_RD1_W;
    localparam int unsigned IDEX_TOTAL_W       = IDEX_PC_LSB + IDEX_PC_W;

    // Packed view of the ID/EX payload; field order matches the offsets above
    typedef struct packed {
        logic [IDEX_PC_W-1:0]        pc;
        logic [IDEX_RD1_W-1:0]       rd1;
        logic [IDEX_RD2_W-1:0]       rd2;
        logic [IDEX_IMM_W-1:0]       imm;
        logic [IDEX_RT_W-1:0]        rt;
        logic [IDEX_RD_W-1:0]        rd;
        logic [IDEX_OPCODE_W-1:0]    opcode;
        logic [IDEX_OPERATION_W-1:0] operation;
        logic [IDEX_JADDR_W-1:0]     jump_addr;
    } idex_payload_t;

    // Extract the two-bit ALUOp field from a control word
    function automatic logic [CTRL_ALUOP_W-1:0] ctrl_alu_op(
        input logic [IDEX_CTRL_W-1:0] ctrl
    );
        return ctrl[CTRL_ALUOP_LSB +: CTRL_ALUOP_W];
    endfunction

    // True when the control word commits architectural state
    function automatic logic ctrl_has_side_effect(
        input logic [IDEX_CTRL_W-1:0] ctrl
    );
        return ctrl[CTRL_REGWRITE] | ctrl[CTRL_MEMWRITE];
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the stage: valid bit, control field and payload.
// Clear kills the entry and forces control to CTRL_RST while keeping data.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned          CTRL_W   = IDEX_CTRL_W,
    parameter int unsigned          DATA_W   = IDEX_DATA_W,
    parameter logic [CTRL_W-1:0]    CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Clear has priority over load so a kill cannot be overridden
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_RST;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_RST;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, a skid slot
// so back-pressure never drops data, and a synchronous flush for redirects.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned          CTRL_W   = IDEX_CTRL_W,
    parameter int unsigned          DATA_W   = IDEX_DATA_W,
    parameter logic [CTRL_W-1:0]    CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              w_m_valid;
    logic [CTRL_W-1:0] w_m_ctrl;
    logic [DATA_W-1:0] w_m_data;
    logic              w_s_valid;
    logic [CTRL_W-1:0] w_s_ctrl;
    logic [DATA_W-1:0] w_s_data;

    logic              w_acc;
    logic              w_drn;
    logic              w_m_load;
    logic              w_m_clear;
    logic              w_m_from_s;
    logic              w_s_load;
    logic              w_s_clear;
    logic              w_m_valid_nxt;
    logic              w_s_valid_nxt;
    logic [CTRL_W-1:0] w_m_ctrl_in;
    logic [DATA_W-1:0] w_m_data_in;

    logic              r_in_ready;
    logic [1:0]        r_occupancy;

    assign w_acc = in_valid & r_in_ready;
    assign w_drn = w_m_valid & out_ready;

    // Slot control: flush, then refill/shift of M and skid capture, else hold
    always_comb begin
        w_m_load      = 1'b0;
        w_m_clear     = 1'b0;
        w_m_from_s    = 1'b0;
        w_s_load      = 1'b0;
        w_s_clear     = 1'b0;
        w_m_valid_nxt = w_m_valid;
        w_s_valid_nxt = w_s_valid;

        if (flush) begin
            w_m_clear     = 1'b1;
            w_s_clear     = 1'b1;
            w_m_valid_nxt = 1'b0;
            w_s_valid_nxt = 1'b0;
        end else begin
            if (!w_m_valid || w_drn) begin
                if (w_s_valid) begin
                    w_m_load      = 1'b1;
                    w_m_from_s    = 1'b1;
                    w_s_clear     = 1'b1;
                    w_m_valid_nxt = 1'b1;
                    w_s_valid_nxt = 1'b0;
                end else if (w_acc) begin
                    w_m_load      = 1'b1;
                    w_m_valid_nxt = 1'b1;
                end else begin
                    w_m_clear     = 1'b1;
                    w_m_valid_nxt = 1'b0;
                end
            end
            // M is stalled with a live entry: park the new one in the skid slot
            if (w_acc && w_m_valid && !out_ready && !w_s_valid) begin
                w_s_load      = 1'b1;
                w_s_valid_nxt = 1'b1;
            end
        end
    end

    assign w_m_ctrl_in = w_m_from_s ? w_s_ctrl : in_ctrl;
    assign w_m_data_in = w_m_from_s ? w_s_data : in_data;

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_RST (CTRL_RST)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_m_load),
        .i_clear (w_m_clear),
        .i_valid (1'b1),
        .i_ctrl  (w_m_ctrl_in),
        .i_data  (w_m_data_in),
        .o_valid (w_m_valid),
        .o_ctrl  (w_m_ctrl),
        .o_data  (w_m_data)
    );

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_RST (CTRL_RST)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_s_load),
        .i_clear (w_s_clear),
        .i_valid (1'b1),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_s_valid),
        .o_ctrl  (w_s_ctrl),
        .o_data  (w_s_data)
    );

    // Ready and occupancy registered from next-state so out_ready never reaches in_ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready  <= 1'b1;
            r_occupancy <= 2'd0;
        end else begin
            r_in_ready  <= ~w_s_valid_nxt;
            r_occupancy <= 2'({1'b0, w_m_valid_nxt}) + 2'({1'b0, w_s_valid_nxt});
        end
    end

    assign in_ready  = r_in_ready;
    assign occupancy = r_occupancy;
    assign out_valid = w_m_valid;
    assign out_ctrl  = w_m_ctrl;
    assign out_data  = w_m_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks of the elastic stage register.
module tb_pipe_stage_reg;

    localparam int unsigned CTRL_W = 11;
    localparam int unsigned DATA_W = 147;

    typedef logic [159:0] chk_t;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    int n_checks;
    int n_errors;

    pipe_stage_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_RST ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input chk_t act, input chk_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                               input logic [DATA_W-1:0] d, input logic [1:0] occ, input logic rdy);
        check({tag, ".out_valid"}, chk_t'(out_valid), chk_t'(v));
        check({tag, ".out_ctrl"},  chk_t'(out_ctrl),  chk_t'(c));
        check({tag, ".out_data"},  chk_t'(out_data),  chk_t'(d));
        check({tag, ".occupancy"}, chk_t'(occupancy), chk_t'(occ));
        check({tag, ".in_ready"},  chk_t'(in_ready),  chk_t'(rdy));
    endtask

    logic [DATA_W-1:0] q_data[$];
    logic [CTRL_W-1:0] q_ctrl[$];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset held for three cycles
        repeat (3) tick();
        check_state("reset", 1'b0, '0, '0, 2'd0, 1'b1);
        rst = 1'b1;

        // Stream 1..4 with no back-pressure
        in_valid = 1'b1;
        in_ctrl  = 11'h009;
        for (int i = 1; i <= 4; i++) begin
            in_data = DATA_W'(i);
            tick();
            check_state($sformatf("stream%0d", i), 1'b1, 11'h009, DATA_W'(i), 2'd1, 1'b1);
        end

        // Two bubble cycles: ctrl returns to reset value, data held
        in_valid = 1'b0;
        tick();
        check_state("bubble1", 1'b0, '0, DATA_W'(4), 2'd0, 1'b1);
        tick();
        check_state("bubble2", 1'b0, '0, DATA_W'(4), 2'd0, 1'b1);

        // Stall with skid: 5 in M, 6 into S, 7 refused
        in_valid = 1'b1; in_ctrl = 11'h003; in_data = DATA_W'(5);
        tick();
        check_state("stall_m5", 1'b1, 11'h003, DATA_W'(5), 2'd1, 1'b1);
        out_ready = 1'b0; in_data = DATA_W'(6);
        tick();
        check_state("stall_s6", 1'b1, 11'h003, DATA_W'(5), 2'd2, 1'b0);
        in_data = DATA_W'(7);
        tick();
        check_state("stall_ref7", 1'b1, 11'h003, DATA_W'(5), 2'd2, 1'b0);
        out_ready = 1'b1; in_valid = 1'b0;
        tick();
        check_state("drain6", 1'b1, 11'h003, DATA_W'(6), 2'd1, 1'b1);
        tick();
        check_state("drain_empty", 1'b0, '0, DATA_W'(6), 2'd0, 1'b1);

        // Flush with both slots full; same-cycle input 10 must vanish
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 11'h0FF; in_data = DATA_W'(8);
        tick();
        in_data = DATA_W'(9);
        tick();
        check_state("pre_flush", 1'b1, 11'h0FF, DATA_W'(8), 2'd2, 1'b0);
        flush = 1'b1; in_data = DATA_W'(10);
        tick();
        check_state("flush_full", 1'b0, '0, DATA_W'(8), 2'd0, 1'b1);
        // Flush on an empty stage with an accepted input: entry 11 discarded
        in_data = DATA_W'(11); out_ready = 1'b1;
        tick();
        check_state("flush_acc", 1'b0, '0, DATA_W'(8), 2'd0, 1'b1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check_state("post_flush", 1'b0, '0, DATA_W'(8), 2'd0, 1'b1);

        // Async reset in the middle of a stall
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 11'h0FF; in_data = DATA_W'(12);
        tick();
        in_data = DATA_W'(13);
        tick();
        check_state("pre_rst", 1'b1, 11'h0FF, DATA_W'(12), 2'd2, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_state("async_rst", 1'b0, '0, '0, 2'd0, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check_state("post_rst", 1'b0, '0, '0, 2'd0, 1'b1);

        // Random valid/ready/flush against a scoreboard queue
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic m_rdy;
            logic m_acc;
            logic m_drn;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            in_data   = {DATA_W'($urandom), 32'($urandom)};
            in_ctrl   = CTRL_W'($urandom_range(1, 2047));
            m_rdy = (q_data.size() < 2);
            m_acc = in_valid && m_rdy;
            m_drn = (q_data.size() > 0) && out_ready;
            tick();
            if (flush) begin
                q_data.delete();
                q_ctrl.delete();
            end else begin
                if (m_drn) begin
                    void'(q_data.pop_front());
                    void'(q_ctrl.pop_front());
                end
                if (m_acc) begin
                    q_data.push_back(in_data);
                    q_ctrl.push_back(in_ctrl);
                end
            end
            check("rnd.out_valid", chk_t'(out_valid), chk_t'(q_data.size() > 0));
            check("rnd.occupancy", chk_t'(occupancy), chk_t'(q_data.size()));
            check("rnd.in_ready", chk_t'(in_ready), chk_t'(q_data.size() < 2));
            if (q_data.size() > 0) begin
                check("rnd.out_data", chk_t'(out_data), chk_t'(q_data[0]));
                check("rnd.out_ctrl", chk_t'(out_ctrl), chk_t'(q_ctrl[0]));
            end else begin
                check("rnd.bubble_ctrl", chk_t'(out_ctrl), chk_t'(0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register; the generic successor to the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data payload with a valid/ready handshake and a 2-entry skid buffer, so back-pressure never drops data.
- Synchronous flush inserts bubbles on branch/jump redirect.
- One instance sits between each pair of CPU stages.

Parameters:
- CTRL_W, 11: control-bit width (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp[1:0], spare).
- DATA_W, 147: payload width (pc, RD1, RD2, imm, rt, rd, opcode, operation, jump_addr in the ID/EX use).
- CTRL_RST, 0: control value forced on bubbles and reset; CTRL_W bits.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- flush, in, 1: synchronous kill of all held entries.
- in_valid, in, 1: upstream entry present.
- in_ready, out, 1: stage can accept this cycle.
- in_ctrl, in, CTRL_W: upstream control bits.
- in_data, in, DATA_W: upstream payload.
- out_valid, out, 1: main slot holds a live entry.
- out_ready, in, 1: downstream accepts; deasserted means stall.
- out_ctrl, out, CTRL_W: control bits of the main slot.
- out_data, out, DATA_W: payload of the main slot.
- occupancy, out, 2: live entries held, 0..2.

Behaviour:
- Storage: main slot M (drives the outputs) and skid slot S. Each slot holds a valid bit, ctrl and data.
- Reset (rst=0, asynchronous): M.valid=S.valid=0, ctrl=CTRL_RST, data=0. During and after reset: out_valid=0, out_ctrl=CTRL_RST, out_data=0, occupancy=0, in_ready=1.
- in_ready = !S.valid. It is a register output with no combinational path from out_ready.
- acc = in_valid & in_ready. drn = out_valid & out_ready.
- Priority, highest first:
  1. flush
  2. load/shift
  3. hold
- flush=1: next cycle M.valid=S.valid=0 and both ctrl=CTRL_RST. Data is unchanged. A same-cycle acc entry is discarded. A same-cycle drn still completes downstream.
- M loads when !M.valid or drn:
  - S.valid: M<=S, S.valid<=0.
  - else if acc: M<=input.
  - else: M.valid<=0 and M.ctrl<=CTRL_RST, i.e. a bubble.
- S loads when acc, M.valid, !out_ready and !S.valid: S<=input, so in_ready falls next cycle.
- acc while M drains and S is empty: input goes straight to M. Throughput is 1 entry/cycle.
- Latency: 1 cycle from acc to out_valid with an empty stage. out_data equals in_data of that cycle.
- Ordering is strictly FIFO. No entry is duplicated or lost except by flush.
- out_ctrl equals CTRL_RST whenever out_valid=0, so downstream may ignore out_valid for write enables.
- out_valid, once asserted, holds with stable ctrl/data until drn or flush.
- occupancy = M.valid + S.valid, registered.
- Simultaneous cases:
  - acc and drn with S full is impossible, because in_ready=0.
  - flush during reset: reset wins.
  - Reset mid-stall: all entries lost, outputs at reset values immediately.

Decomposition:
- Package pipe_pkg:
  - Control-bit index constants: CTRL_REGDST=0, CTRL_ALUSRC=1, CTRL_MEMTOREG=2, CTRL_REGWRITE=3, CTRL_MEMREAD=4, CTRL_MEMWRITE=5, CTRL_BRANCH=6, CTRL_JUMP=7, CTRL_ALUOP_LSB=8.
  - Default CTRL_W/DATA_W per stage.
  - ID/EX payload field offsets (pc, rd1, rd2, imm, rt, rd, opcode, operation, jump_addr).
- Sub-module pipe_slot: one valid+ctrl+data register with load, clear-to-CTRL_RST and async reset, instantiated twice (M, S).

Test Plan:
- Reset then stream: rst low 3 cycles, then in_valid=1 with in_data=1,2,3,4 on consecutive cycles and out_ready=1 → out_data=1,2,3,4 one cycle later each; in_ready stays 1; occupancy=1.
- Stall with skid: M holds 5, out_ready=0, push 6 → in_ready=0 and occupancy=2 next cycle; push 7 is refused; out_ready=1 → outputs 5 then 6; in_ready=1 again.
- Flush: occupancy=2 with entries 8,9 and in_ctrl=11'h0FF; flush=1 with in_valid=1 carrying 10 → next cycle out_valid=0, out_ctrl=0, occupancy=0; 10 never appears.
- Bubble: in_valid=0 for 2 cycles with out_ready=1 → out_valid=0 and out_ctrl=CTRL_RST both cycles; last out_data is held.
- Async reset mid-stall: occupancy=2, assert rst between clock edges → outputs zero immediately; after release in_ready=1 and occupancy=0.
- Random valid/ready for 10k cycles against a scoreboard queue → in-order delivery, no loss or duplication, out_ctrl=0 whenever out_valid=0.
